// File: rtl/bram_burst_arbiter_if.sv
// ============================================================================
// Module  : bram_burst_arbiter_if
// Brief   : Requester / BRAM-write-port bundle shared by the burst arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_burst_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] reqData;
   logic [NUM_REQ-1:0]        grant;
   logic                      bramWen;
   logic [ADDR_W-1:0]         bramAddr;
   logic [DATA_W-1:0]         bramDin;
   logic                      burstDone;

   modport master (
      output req, reqData,
      input  grant, bramWen, bramAddr, bramDin, burstDone
   );

   modport slave (
      input  req, reqData,
      output grant, bramWen, bramAddr, bramDin, burstDone
   );
endinterface

`default_nettype wire

// File: rtl/bram_burst_arbiter.sv
// ============================================================================
// Module  : bram_burst_arbiter
// Brief   : Shares one BRAM write port among NUM_REQ requesters in fixed-length
//           bursts; round-robin by default, fixed priority when
//           BRAM_ARB_FIXED_PRIORITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_burst_arbiter #(
   parameter int NUM_REQ   = 3,
   parameter int BURST_LEN = 4,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   bram_burst_arbiter_if.slave   bus
);

   localparam int CNT_W = $clog2(BURST_LEN);
   localparam int PTR_W = ADDR_W - 2;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   // Holds the current grantee during a burst and doubles as lastWinner after it.
   logic [1:0]       r_winner;
   logic [1:0]       w_winner_nxt;
   logic [CNT_W-1:0] r_beat;
   logic [CNT_W-1:0] w_beat_nxt;
   logic [PTR_W-1:0] r_ptr [NUM_REQ];

   logic [3:0]       w_req4;
   logic             w_arb_valid;
   logic [1:0]       w_arb_idx;
   logic [3:0]       w_grant4;
   logic [PTR_W-1:0] w_cur_ptr;
   logic [DATA_W-1:0] w_cur_data;

   assign w_req4      = 4'(bus.req);
   assign w_arb_valid = |bus.req;
   assign w_grant4    = 4'b0001 << r_winner;

   always_comb begin : arbiter
      logic [2:0] sum;
      logic       found;
      sum       = '0;
      found     = 1'b0;
      w_arb_idx = r_winner;
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
      for (int i = 3; i >= 0; i--) begin
         if (w_req4[2'(i)]) begin
            w_arb_idx = 2'(i);
            found     = 1'b1;
         end
      end
`else
      // Search order starts one past the previous winner, modulo NUM_REQ.
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, r_winner} + 3'(k);
         if (sum >= 3'(NUM_REQ)) begin
            sum = sum - 3'(NUM_REQ);
         end
         if (!found && w_req4[sum[1:0]]) begin
            w_arb_idx = sum[1:0];
            found     = 1'b1;
         end
      end
`endif
   end

   always_comb begin : winner_mux
      w_cur_ptr  = '0;
      w_cur_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_winner == 2'(i)) begin
            w_cur_ptr  = r_ptr[i];
            w_cur_data = bus.reqData[i*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.bramAddr = {r_winner, w_cur_ptr};
   assign bus.bramDin  = w_cur_data;

   always_comb begin : fsm_next
      w_state_nxt   = r_state;
      w_winner_nxt  = r_winner;
      w_beat_nxt    = r_beat;
      bus.grant     = '0;
      bus.bramWen   = 1'b0;
      bus.burstDone = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_arb_valid) begin
               w_state_nxt  = BURST;
               w_winner_nxt = w_arb_idx;
               w_beat_nxt   = '0;
            end
         end
         BURST: begin
            bus.grant   = w_grant4[NUM_REQ-1:0];
            bus.bramWen = 1'b1;
            w_beat_nxt  = r_beat + CNT_W'(1);
            if (r_beat == LAST_BEAT) begin
               bus.burstDone = 1'b1;
               w_beat_nxt    = '0;
               // Back-to-back burst when anyone is asking on the last beat.
               if (w_arb_valid) begin
                  w_winner_nxt = w_arb_idx;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin : state_reg
      if (reset) begin
         r_state  <= IDLE;
         r_winner <= 2'(NUM_REQ - 1);
         r_beat   <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            r_ptr[i] <= '0;
         end
      end else begin
         r_state  <= w_state_nxt;
         r_winner <= w_winner_nxt;
         r_beat   <= w_beat_nxt;
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((r_state == BURST) && (r_winner == 2'(i))) begin
               r_ptr[i] <= r_ptr[i] + PTR_W'(1);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bram_burst_arbiter.sv
// ============================================================================
// Module  : tb_bram_burst_arbiter
// Brief   : Directed scoreboard bench for bram_burst_arbiter (3 req, 4 beats).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_burst_arbiter;

   localparam int NUM_REQ   = 3;
   localparam int BURST_LEN = 4;
   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 16;

   typedef struct packed {
      logic        wen;
      logic [2:0]  grant;
      logic [7:0]  addr;
      logic [15:0] din;
      logic        done;
   } exp_t;

   logic clk;
   logic reset;
   int   passed;
   int   failed;
   int   total;
   exp_t sb[$];
   logic [5:0] mptr [3];
   int   wins [4];

   bram_burst_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   bram_burst_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .BURST_LEN (BURST_LEN),
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic push_idle();
      exp_t e;
      e = '0;
      sb.push_back(e);
   endtask

   task automatic push_burst(input int w);
      exp_t e;
      logic [1:0] wi;
      wi = 2'(w);
      for (int b = 0; b < BURST_LEN; b++) begin
         e       = '0;
         e.wen   = 1'b1;
         e.grant = 3'b001 << w;
         e.addr  = {wi, mptr[w]};
         e.din   = bus.reqData[w*DATA_W +: DATA_W];
         e.done  = (b == BURST_LEN - 1);
         sb.push_back(e);
         mptr[w] = mptr[w] + 6'd1;
      end
   endtask

   task automatic chk_slot();
      exp_t e;
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("bramWen", 32'(bus.bramWen), 32'(e.wen));
         check("grant", 32'(bus.grant), 32'(e.grant));
         check("burstDone", 32'(bus.burstDone), 32'(e.done));
         if (e.wen) begin
            check("bramAddr", 32'(bus.bramAddr), 32'(e.addr));
            check("bramDin", 32'(bus.bramDin), 32'(e.din));
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         next();
         chk_slot();
      end
   endtask

   task automatic set_data();
      bus.reqData = {16'($urandom), 16'($urandom), 16'($urandom)};
   endtask

   // Asynchronous reset: outputs must drop before any clock edge.
   task automatic reset_now();
      reset = 1'b1;
      #1;
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_bramWen", 32'(bus.bramWen), 32'd0);
      check("rst_burstDone", 32'(bus.burstDone), 32'd0);
      sb.delete();
      next();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) mptr[i] = '0;
   endtask

   task automatic do_reset();
      next();
      reset_now();
   endtask

   initial begin
      passed      = 0;
      failed      = 0;
      total       = 0;
      reset       = 1'b0;
      bus.req     = '0;
      bus.reqData = '0;
      for (int i = 0; i < 3; i++) mptr[i] = '0;
      #1;
      reset_now();

      // Single requester 1, two bursts then idle.
      next();
      set_data();
      bus.req = 3'b010;
      push_idle();
      push_burst(1);
      push_burst(1);
      chk_slot();
      run(7);
      next();
      bus.req = 3'b000;
      chk_slot();
      push_idle();
      run(1);

      // All requesting after reset.
      do_reset();
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
      wins = '{0, 0, 0, 0};
`else
      wins = '{0, 1, 2, 0};
`endif
      next();
      set_data();
      bus.req = 3'b111;
      push_idle();
      for (int i = 0; i < 4; i++) push_burst(wins[i]);
      chk_slot();
      run(15);
      next();
      bus.req = 3'b000;
      chk_slot();
      push_idle();
      run(1);

      // Requester 2 drops its request mid-burst.
      next();
      set_data();
      bus.req = 3'b100;
      push_idle();
      push_burst(2);
      chk_slot();
      next();
      chk_slot();
      next();
      chk_slot();
      next();
      bus.req = 3'b000;
      chk_slot();
      next();
      chk_slot();
      push_idle();
      run(1);

      // Requesters 0 and 2 held.
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
      wins = '{0, 0, 0, 0};
`else
      wins = '{0, 2, 0, 2};
`endif
      next();
      set_data();
      bus.req = 3'b101;
      push_idle();
      for (int i = 0; i < 4; i++) push_burst(wins[i]);
      chk_slot();
      run(15);
      next();
      bus.req = 3'b000;
      chk_slot();
      push_idle();
      run(1);

      // Region wrap: requester 0 alone for 17 bursts.
      do_reset();
      next();
      set_data();
      bus.req = 3'b001;
      push_idle();
      for (int i = 0; i < 17; i++) push_burst(0);
      chk_slot();
      run(67);
      next();
      bus.req = 3'b000;
      chk_slot();
      push_idle();
      run(1);

      // Reset during beat 2 of a requester-1 burst.
      next();
      set_data();
      bus.req = 3'b010;
      push_idle();
      push_burst(1);
      chk_slot();
      run(2);
      next();
      chk_slot();
      reset_now();
      set_data();
      bus.req = 3'b011;
      push_idle();
      push_burst(0);
      chk_slot();
      run(3);
      next();
      bus.req = 3'b000;
      chk_slot();
      push_idle();
      run(1);

      check("sb_drained", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
